tsensor_array_ctrl: RTL and testbench
=====================================

// Module: tsensor_array_ctrl
// PURPOSE
//  Sequencer/monitor for the 32-channel timing-sensor array (16 tsensor + 16 tsensor_inv).
//  Drives the array's sensor reset and the shared stimulus bus s.
//  Samples and masks the per-channel alarm vector, keeps sticky status and a saturating event count.
//  Raises irq when events within a programmable window reach a threshold.
//  Sits between the array and the coprocessor register file.
// PARAMETERS
//  N        32  sensor channels (alarm/s width)
//  CLR_CYC  4   cycles sens_rst held high per (re)arm
//  ARM_CYC  8   settle cycles after sens_rst before sampling
//  CNT_W    16  event counter / threshold width
//  WIN_W    16  window length width
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  en         in   1      monitor enable (level)
//  mask       in   N      1 = ignore channel
//  win_len    in   WIN_W  observation window, cycles (0 treated as 1)
//  thresh     in   CNT_W  window events needed to raise irq (0 treated as 1)
//  irq_clr    in   1      1-cycle pulse: clears irq and status
//  sens_alarm in   N      alarm vector from array
//  sens_rst   out  1      reset to array
//  sens_s     out  N      stimulus to array
//  status     out  N      sticky masked alarms
//  evt_cnt    out  CNT_W  total events, saturating
//  busy       out  1      1 in CLR/ARM
//  irq        out  1      sticky interrupt
// BEHAVIOUR
//  Reset values: sens_rst=1, sens_s=0, status=0, evt_cnt=0, busy=0, irq=0, FSM=IDLE.
//  FSM: IDLE -> CLR -> ARM -> MON.
//   - IDLE: sens_rst=1, sens_s=0. Go to CLR when en=1.
//   - CLR: sens_rst=1 for CLR_CYC cycles, then ARM.
//   - ARM: sens_rst=0, sens_s=0 for ARM_CYC cycles, then MON.
//   - MON: sens_rst=0; sens_s = all-ones/all-zeros, inverted every cycle, starting with all-ones.
//  en=0 in any state -> IDLE next cycle. Window and FSM counters cleared; status, evt_cnt and irq kept.
//  Sampling:
//   - alarm_q <= sens_alarm every cycle (1-stage register).
//   - hit = alarm_q & ~mask, qualified only when FSM was MON in both this cycle and the previous one.
//   - Latency: alarm edge -> status/evt_cnt update is 2 cycles.
//  On qualified hit != 0 (one event, regardless of popcount):
//   - status |= hit.
//   - evt_cnt += 1, saturating at all-ones.
//   - win_evt += 1, saturating.
//   - FSM -> CLR (re-arm). Alarms during CLR/ARM are ignored.
//  Window: win_ctr counts cycles in MON/CLR/ARM while en=1.
//   - At win_ctr == max(win_len,1)-1: if win_evt (including this cycle's event) >= max(thresh,1), set irq.
//     Then win_ctr=0 and win_evt=0.
//  irq_clr clears irq and status. A same-cycle irq set or status update wins over the clear.
//  mask/win_len/thresh changes take effect on the next cycle; no re-arm.
//  rst mid-operation: everything returns to reset values next cycle, with sens_rst=1 immediately registered.
// STRUCTURE
//  Package tsensor_pkg: N, CNT_W, WIN_W, FSM state encoding localparams (IDLE/CLR/ARM/MON).
//  One sub-module: tsensor_win_ctr (window cycle counter + window event counter + threshold compare, emits irq_set).
//  FSM, sampling and status stay in the top module.
// TESTING
//  1. rst, then en=1: sens_rst high exactly 4 cycles, low 8 cycles, then sens_s toggles FFFFFFFF/00000000 each cycle; busy matches.
//  2. MON, mask=0, pulse sens_alarm[17]: status=0x00020000, evt_cnt=1, both 2 cycles later; FSM re-enters CLR (sens_rst=1).
//  3. mask=0x00020000, repeat test 2: no status, count or re-arm change. Alarm during CLR/ARM: ignored.
//  4. win_len=100, thresh=3, three unmasked alarms in a window: irq=1 at window end; two alarms -> irq stays 0.
//  5. irq_clr on the same cycle as a new hit: status shows the new bit and irq remains set if its set coincides.
//     Preset evt_cnt at FFFF: next hit keeps FFFF.
//  6. en=0 mid-ARM -> IDLE next cycle, sens_rst=1. rst mid-MON -> all reset values next cycle.

Source files
------------

// File: rtl/tsensor_pkg.sv
// Shared sizing and FSM encoding for the timing-sensor array controller.
package tsensor_pkg;

  localparam int N       = 32;
  localparam int CNT_W   = 16;
  localparam int WIN_W   = 16;
  localparam int CLR_CYC = 4;
  localparam int ARM_CYC = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_ARM  = 2'd2,
    ST_MON  = 2'd3
  } fsm_t;

endpackage

// File: rtl/tsensor_win_ctr.sv
// Observation-window cycle counter and window event counter; flags irq_set
// when a window closes with at least thresh events.
module tsensor_win_ctr #(
  parameter int CNT_W = tsensor_pkg::CNT_W,
  parameter int WIN_W = tsensor_pkg::WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             evt,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic             irq_set
);

  logic [WIN_W-1:0] win_ctr;
  logic [WIN_W-1:0] win_lim;
  logic [CNT_W-1:0] win_evt;
  logic [CNT_W-1:0] evt_now;
  logic [CNT_W-1:0] thr;
  logic             wrap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // >= rather than == so a window shortened on the fly closes at once
  always_comb begin
    win_lim = (win_len == '0) ? WIN_W'(1) : win_len;
    thr     = (thresh == '0) ? CNT_W'(1) : thresh;
    evt_now = evt ? sat_inc(win_evt) : win_evt;
    wrap    = run && (win_ctr >= win_lim - 1'b1);
    irq_set = wrap && (evt_now >= thr);
  end

  always_ff @(posedge clk) begin
    if (rst || !run || wrap) begin
      win_ctr <= '0;
      win_evt <= '0;
    end else begin
      win_ctr <= win_ctr + 1'b1;
      win_evt <= evt_now;
    end
  end

endmodule

// File: rtl/tsensor_array_ctrl.sv
// Sequencer/monitor for the 32-channel timing-sensor array: arms the array,
// drives the toggling stimulus, collects masked alarms and raises irq.
module tsensor_array_ctrl #(
  parameter int N       = tsensor_pkg::N,
  parameter int CLR_CYC = tsensor_pkg::CLR_CYC,
  parameter int ARM_CYC = tsensor_pkg::ARM_CYC,
  parameter int CNT_W   = tsensor_pkg::CNT_W,
  parameter int WIN_W   = tsensor_pkg::WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     mask,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_clr,
  input  logic [N-1:0]     sens_alarm,
  output logic             sens_rst,
  output logic [N-1:0]     sens_s,
  output logic [N-1:0]     status,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             busy,
  output logic             irq
);
  import tsensor_pkg::*;

  localparam int PH_MAX = (CLR_CYC > ARM_CYC) ? CLR_CYC : ARM_CYC;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] CLR_LAST = PH_W'(CLR_CYC - 1);
  localparam logic [PH_W-1:0] ARM_LAST = PH_W'(ARM_CYC - 1);

  fsm_t            state;
  logic [PH_W-1:0] ph_cnt;
  logic [N-1:0]    alarm_p1;
  logic            vld_p1;
  logic [N-1:0]    hit_p1;
  logic            evt_p1;
  logic            win_run;
  logic            irq_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p1: raw alarm capture; vld_p1 remembers the FSM was already monitoring
  always_ff @(posedge clk) begin
    alarm_p1 <= sens_alarm;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= (state == ST_MON);
  end

  assign hit_p1  = (vld_p1 && state == ST_MON) ? (alarm_p1 & ~mask) : '0;
  assign evt_p1  = |hit_p1;
  assign win_run = en && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state    <= ST_IDLE;
      ph_cnt   <= '0;
      sens_rst <= 1'b1;
      sens_s   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_CLR;
          ph_cnt   <= '0;
          sens_rst <= 1'b1;
          sens_s   <= '0;
          busy     <= 1'b1;
        end
        ST_CLR: begin
          if (ph_cnt == CLR_LAST) begin
            state    <= ST_ARM;
            ph_cnt   <= '0;
            sens_rst <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_ARM: begin
          if (ph_cnt == ARM_LAST) begin
            state  <= ST_MON;
            ph_cnt <= '0;
            sens_s <= '1;
            busy   <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_MON: begin
          if (evt_p1) begin
            state    <= ST_CLR;
            ph_cnt   <= '0;
            sens_rst <= 1'b1;
            sens_s   <= '0;
            busy     <= 1'b1;
          end else begin
            sens_s <= ~sens_s;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tsensor_win_ctr #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .run     (win_run),
    .evt     (evt_p1),
    .win_len (win_len),
    .thresh  (thresh),
    .irq_set (irq_set)
  );

  // Stage p2: sticky state; a same-cycle set or new hit beats irq_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      status  <= '0;
      evt_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      status <= (irq_clr ? '0 : status) | hit_p1;
      if (evt_p1) evt_cnt <= sat_inc(evt_cnt);
      irq <= irq_set | (irq & ~irq_clr);
    end
  end

endmodule

// File: tb/tb_tsensor_array_ctrl.sv
// Directed bench for tsensor_array_ctrl: per-cycle vector table for bring-up
// and alarm handling, plus hand-written window, irq_clr, saturation and abort cases.
module tb_tsensor_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] mask;
  logic [15:0] win_len;
  logic [15:0] thresh;
  logic        irq_clr;
  logic [31:0] sens_alarm;
  logic        sens_rst;
  logic [31:0] sens_s;
  logic [31:0] status;
  logic [15:0] evt_cnt;
  logic        busy;
  logic        irq;

  logic        en2;
  logic [31:0] mask2;
  logic [15:0] win_len2;
  logic [2:0]  thresh2;
  logic        irq_clr2;
  logic [31:0] alarm2;
  logic        sens_rst2;
  logic [31:0] sens_s2;
  logic [31:0] status2;
  logic [2:0]  evt_cnt2;
  logic        busy2;
  logic        irq2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e1;

  always #5 clk = ~clk;

  tsensor_array_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask), .win_len(win_len), .thresh(thresh),
    .irq_clr(irq_clr), .sens_alarm(sens_alarm), .sens_rst(sens_rst), .sens_s(sens_s),
    .status(status), .evt_cnt(evt_cnt), .busy(busy), .irq(irq)
  );

  tsensor_array_ctrl #(.CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mask(mask2), .win_len(win_len2), .thresh(thresh2),
    .irq_clr(irq_clr2), .sens_alarm(alarm2), .sens_rst(sens_rst2), .sens_s(sens_s2),
    .status(status2), .evt_cnt(evt_cnt2), .busy(busy2), .irq(irq2)
  );

  typedef struct {
    logic [31:0] alarm;
    logic [31:0] mask;
    logic        exp_rst;
    logic [31:0] exp_s;
    logic        exp_busy;
    logic [31:0] exp_status;
    logic [15:0] exp_evt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic [31:0] m, input logic r,
                     input logic [31:0] s, input logic b, input logic [31:0] st,
                     input logic [15:0] ev);
    vec_t v;
    v.alarm = a; v.mask = m; v.exp_rst = r; v.exp_s = s;
    v.exp_busy = b; v.exp_status = st; v.exp_evt = ev;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_mon();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_mon: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic wait_mon2();
    int n = 0;
    while (busy2 && n < 40) begin
      step();
      n++;
    end
    if (busy2) begin
      checks++;
      errors++;
      $display("FAIL wait_mon2: busy2 still %b after %0d cycles", busy2, n);
    end
  endtask

  // Alarm pulse one cycle into MON; outputs are checked two edges after capture.
  task automatic fire(input int b, input logic [15:0] ev, input logic [31:0] st);
    wait_mon();
    sens_alarm = 32'd1 << b;
    step();
    sens_alarm = '0;
    step();
    chk("fire_evt", 32'(evt_cnt), 32'(ev));
    chk("fire_status", status, st);
    chk("fire_rearm", 32'(sens_rst), 32'd1);
  endtask

  task automatic fire2(input int b, input logic [2:0] ev);
    wait_mon2();
    alarm2 = 32'd1 << b;
    step();
    alarm2 = '0;
    step();
    chk("sat_evt", 32'(evt_cnt2), 32'(ev));
  endtask

  initial begin
    logic [31:0] ff;
    logic [31:0] m17;
    ff  = 32'hFFFF_FFFF;
    m17 = 32'h0002_0000;

    // Bring-up, single hit, ignored alarms during CLR/ARM, masked and multi-bit hits
    for (int i = 1; i <= 4; i++)   add(0, 0, 1, 0, 1, 0, 0);
    for (int i = 5; i <= 12; i++)  add(0, 0, 0, 0, 1, 0, 0);
    for (int i = 13; i <= 20; i++) add(0, 0, 0, (i % 2 == 1) ? ff : 32'd0, 0, 0, 0);
    add(m17, 0, 0, ff, 0, 0, 0);
    for (int i = 22; i <= 25; i++) add(0, 0, 1, 0, 1, m17, 1);
    for (int i = 26; i <= 33; i++) add((i == 28) ? 32'h8 : 32'd0, 0, 0, 0, 1, m17, 1);
    add(32'h8, 0,   0, ff, 0, m17, 1);
    add(0,     0,   0, 0,  0, m17, 1);
    add(0,     m17, 0, ff, 0, m17, 1);
    add(m17,   m17, 0, 0,  0, m17, 1);
    add(0,     m17, 0, ff, 0, m17, 1);
    add(32'h0002_0021, m17, 0, 0, 0, m17, 1);
    add(0,     m17, 1, 0,  1, 32'h0002_0021, 2);

    rst = 1'b1; en = 1'b0; mask = '0; win_len = 16'd1000; thresh = 16'd100;
    irq_clr = 1'b0; sens_alarm = '0;
    en2 = 1'b0; mask2 = '0; win_len2 = 16'hFFFF; thresh2 = 3'd7; irq_clr2 = 1'b0; alarm2 = '0;
    repeat (3) step();
    chk("rst_sens_rst", 32'(sens_rst), 32'd1);
    chk("rst_sens_s", sens_s, 32'd0);
    chk("rst_status", status, 32'd0);
    chk("rst_evt", 32'(evt_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst2_evt", 32'(evt_cnt2), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_sens_rst", 32'(sens_rst), 32'd1);

    foreach (vecs[k]) begin
      en = 1'b1;
      sens_alarm = vecs[k].alarm;
      mask = vecs[k].mask;
      step();
      chk($sformatf("v%0d_sens_rst", k + 1), 32'(sens_rst), 32'(vecs[k].exp_rst));
      chk($sformatf("v%0d_sens_s", k + 1), sens_s, vecs[k].exp_s);
      chk($sformatf("v%0d_busy", k + 1), 32'(busy), 32'(vecs[k].exp_busy));
      chk($sformatf("v%0d_status", k + 1), status, vecs[k].exp_status);
      chk($sformatf("v%0d_evt", k + 1), 32'(evt_cnt), 32'(vecs[k].exp_evt));
      chk($sformatf("v%0d_irq", k + 1), 32'(irq), 32'd0);
    end
    sens_alarm = '0;
    mask = '0;

    // Window of 100 cycles, threshold 3: two events must not raise irq
    win_len = 16'd100; thresh = 16'd3;
    en = 1'b0; step(); en = 1'b1; step(); e1 = cyc;
    fire(1, 3, 32'h0002_0023);
    fire(2, 4, 32'h0002_0027);
    while (cyc < e1 + 100) step();
    chk("win2_irq_end", 32'(irq), 32'd0);

    en = 1'b0; step(); en = 1'b1; step(); e1 = cyc;
    fire(3, 5, 32'h0002_002F);
    fire(4, 6, 32'h0002_003F);
    fire(6, 7, 32'h0002_007F);
    while (cyc < e1 + 99) step();
    chk("win3_irq_before_end", 32'(irq), 32'd0);
    step();
    chk("win3_irq_end", 32'(irq), 32'd1);

    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_status", status, 32'd0);

    // Zero win_len/thresh act as 1: every hit sets irq, colliding with irq_clr
    win_len = 16'd0; thresh = 16'd0;
    en = 1'b0; step(); en = 1'b1; step();
    wait_mon();
    sens_alarm = 32'd1 << 9;
    step();
    sens_alarm = '0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("coll_status", status, 32'h0000_0200);
    chk("coll_irq", 32'(irq), 32'd1);
    chk("coll_evt", 32'(evt_cnt), 32'd8);

    // 3-bit counter instance saturates at 7
    en2 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) fire2(i, (i + 1 > 7) ? 3'd7 : 3'(i + 1));
    chk("sat_status", status2, 32'h0000_00FF);

    // en drop mid-ARM, then rst mid-MON
    fire(11, 9, 32'h0000_0A00);
    repeat (5) step();
    chk("arm_sens_rst", 32'(sens_rst), 32'd0);
    chk("arm_busy", 32'(busy), 32'd1);
    en = 1'b0;
    step();
    chk("abort_sens_rst", 32'(sens_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sens_s", sens_s, 32'd0);
    chk("abort_status", status, 32'h0000_0A00);
    chk("abort_evt", 32'(evt_cnt), 32'd9);
    chk("abort_irq", 32'(irq), 32'd1);

    en = 1'b1;
    step();
    wait_mon();
    step();
    step();
    rst = 1'b1;
    step();
    chk("mrst_sens_rst", 32'(sens_rst), 32'd1);
    chk("mrst_sens_s", sens_s, 32'd0);
    chk("mrst_status", status, 32'd0);
    chk("mrst_evt", 32'(evt_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    chk("mrst2_evt", 32'(evt_cnt2), 32'd0);
    rst = 1'b0;
    en = 1'b0;
    en2 = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
